// File: rtl/button_pkg.sv
// Shared types and default timing for the button gesture classifier.
// Default cycle counts assume a 100 MHz system clock.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } press_state_t;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned DCLICK_CYCLES_DEF = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/button_press_classifier.sv
// Turns debounced level/edge pulses into one-cycle short, long, double-click and repeat events.
// All outputs are registered; busy mirrors the state being anything other than IDLE.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned DCLICK_CYCLES = DCLICK_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned REPEAT_EN     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic level,
  input  logic p_edge,
  input  logic n_edge,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_tick,
  output logic busy
);

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  press_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;

  // A simultaneous p_edge/n_edge is treated as n_edge only.
  logic w_press;
  logic w_release;
  logic w_level_unused;

  assign w_press        = p_edge & ~n_edge;
  assign w_release      = n_edge;
  assign w_level_unused = level;

  always_ff @(posedge clk) begin
    short_press  <= 1'b0;
    long_press   <= 1'b0;
    double_click <= 1'b0;
    repeat_tick  <= 1'b0;
    if (reset || !enable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_press) begin
            r_state <= PRESSED;
            busy    <= 1'b1;
          end
        end
        PRESSED: begin
          if (w_release) begin
            r_state <= WAIT_SECOND;
            r_cnt   <= '0;
          end else if (r_cnt == LongLast) begin
            r_state    <= LONG_HELD;
            r_cnt      <= '0;
            long_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        LONG_HELD: begin
          if (w_release) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (REPEAT_EN == 0) begin
            // Untimed without repeats, so the counter can never run away.
            r_cnt <= '0;
          end else if (r_cnt == RepeatLast) begin
            r_cnt       <= '0;
            repeat_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        WAIT_SECOND: begin
          // A press on the timeout cycle still counts as the second click.
          if (w_press) begin
            r_state <= SECOND_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == DclickLast) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            short_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        SECOND_PRESSED: begin
          r_cnt <= '0;
          if (w_release) begin
            r_state      <= IDLE;
            busy         <= 1'b0;
            double_click <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Vector-table bench for button_press_classifier with small timing parameters.
// Instance b has repeats disabled and shares all stimulus with instance a.
module tb_button_press_classifier;

  localparam int Sht = 0;
  localparam int Lng = 1;
  localparam int Dbl = 2;
  localparam int Rep = 3;
  localparam int Bsy = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, level, p_edge, n_edge;
  logic sp_a, lp_a, dc_a, rt_a, bz_a;
  logic sp_b, lp_b, dc_b, rt_b, bz_b;

  button_press_classifier #(
    .CNT_W(8), .LONG_CYCLES(8), .DCLICK_CYCLES(6), .REPEAT_CYCLES(3), .REPEAT_EN(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .level(level), .p_edge(p_edge),
    .n_edge(n_edge), .short_press(sp_a), .long_press(lp_a), .double_click(dc_a),
    .repeat_tick(rt_a), .busy(bz_a)
  );

  button_press_classifier #(
    .CNT_W(8), .LONG_CYCLES(8), .DCLICK_CYCLES(6), .REPEAT_CYCLES(3), .REPEAT_EN(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .level(level), .p_edge(p_edge),
    .n_edge(n_edge), .short_press(sp_b), .long_press(lp_b), .double_click(dc_b),
    .repeat_tick(rt_b), .busy(bz_b)
  );

  // exp bits: {busy, repeat_tick, double_click, long_press, short_press} after the edge
  typedef struct {
    logic       rst;
    logic       en;
    logic       lvl;
    logic       pe;
    logic       ne;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic cyc(input logic rst, input logic en, input logic lvl, input logic pe,
                     input logic ne, input logic bsy);
    vec_t v;
    v.rst = rst;
    v.en  = en;
    v.lvl = lvl;
    v.pe  = pe;
    v.ne  = ne;
    v.exp = {bsy, 4'b0000};
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic lvl, input logic bsy);
    repeat (n) cyc(1'b0, 1'b1, lvl, 1'b0, 1'b0, bsy);
  endtask

  task automatic ev(input int idx, input int b);
    vec_t v;
    v = vecs[idx];
    v.exp[b] = 1'b1;
    vecs[idx] = v;
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got {bsy,rep,dbl,lng,sht}=%b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int         b;
    int         got;
    logic [4:0] e;

    reset  = 1'b1;
    enable = 1'b1;
    level  = 1'b0;
    p_edge = 1'b0;
    n_edge = 1'b0;

    // Reset state
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    hold(2, 0, 0);

    // Short press: released after 3 cycles, window expires 6 edges later
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    hold(2, 1, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(5, 0, 1);
    hold(3, 0, 0);
    ev(b + 9, Sht);

    // Long hold: long at +8, repeats every 3 after, release gives nothing
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    hold(18, 1, 1);
    cyc(0, 1, 0, 0, 1, 0);
    hold(2, 0, 0);
    ev(b + 8, Lng);
    ev(b + 11, Rep);
    ev(b + 14, Rep);
    ev(b + 17, Rep);

    // Double click, then idle past where the window would have expired
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    hold(1, 1, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(2, 0, 1);
    cyc(0, 1, 1, 1, 0, 1);
    hold(1, 1, 1);
    cyc(0, 1, 0, 0, 1, 0);
    hold(8, 0, 0);
    ev(b + 7, Dbl);

    // Second press exactly on the timeout edge wins
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(5, 0, 1);
    cyc(0, 1, 1, 1, 0, 1);
    hold(1, 1, 1);
    cyc(0, 1, 0, 0, 1, 0);
    hold(2, 0, 0);
    ev(b + 9, Dbl);

    // Second press one edge late: short fires, new press starts fresh
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(5, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(5, 0, 1);
    hold(1, 0, 0);
    hold(2, 0, 0);
    ev(b + 7, Sht);
    ev(b + 15, Sht);

    // Reset mid-window discards the pending short press
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(2, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    hold(10, 0, 0);

    // Enable low mid-window does the same
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    hold(2, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    hold(10, 0, 0);

    // Level held through reset with no p_edge: nothing, even on release
    cyc(1, 1, 1, 0, 0, 0);
    hold(10, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    hold(8, 0, 0);

    // Press while disabled is ignored
    cyc(0, 0, 1, 1, 0, 0);
    hold(3, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    hold(2, 0, 0);

    // Both edges at once: n_edge wins, in IDLE and in PRESSED
    cyc(0, 1, 1, 1, 1, 0);
    hold(3, 0, 0);
    b = vecs.size();
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 1, 1, 1);
    hold(5, 0, 1);
    hold(1, 0, 0);
    hold(1, 0, 0);
    ev(b + 7, Sht);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      level  = vecs[i].lvl;
      p_edge = vecs[i].pe;
      n_edge = vecs[i].ne;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("vec_rep_on", i, {bz_a, rt_a, dc_a, lp_a, sp_a}, e);
      check("vec_rep_off", i, {bz_b, rt_b, dc_b, lp_b, sp_b}, e & 5'b10111);
    end

    // Enable dropped in LONG_HELD: bounded wait for long_press, then silence
    reset  = 1'b0;
    enable = 1'b1;
    level  = 1'b1;
    p_edge = 1'b1;
    @(posedge clk);
    #1;
    p_edge = 1'b0;
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (lp_a) begin
        got = k;
        break;
      end
    end
    check_int("long_latency", got, 8);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_in_long", 0, {bz_a, rt_a, dc_a, lp_a, sp_a}, 5'b00000);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("held_after_disable", k, {bz_a, rt_a, dc_a, lp_a, sp_a}, 5'b00000);
    end
    level  = 1'b0;
    n_edge = 1'b1;
    @(posedge clk);
    #1;
    n_edge = 1'b0;
    check("release_after_disable", 0, {bz_a, rt_a, dc_a, lp_a, sp_a}, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
